// File: rtl/fpu_pkg.sv
// Shared fpu definitions: float field constants, rounding-mode encoding,
// int32 saturation limits and the float-to-int converter state/class types.
package fpu_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_INF  = 255;
   localparam int FRAC_W   = 23;
   // Biased exponent at which the significand LSB has weight 1.
   localparam int INT_EXP  = EXP_BIAS + FRAC_W;
   // Biased exponent of 2^31, first magnitude outside int32.
   localparam int OVF_EXP  = EXP_BIAS + 31;

   localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RUP = 2'b10,
      RM_RDN = 2'b11
   } rm_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ROUND,
      ST_DONE
   } fp2int_state_t;

   typedef enum logic [1:0] {
      CLS_NORM,
      CLS_NAN,
      CLS_INF,
      CLS_OVF
   } fp_class_t;

endpackage

// File: rtl/fp2int_round.sv
// Combinational integer rounding: increment decision from guard/sticky,
// sign application and int32 range check with saturation.
module fp2int_round
   import fpu_pkg::*;
(
   input  logic [31:0] mag,
   input  logic        guard,
   input  logic        sticky,
   input  logic        sign,
   input  rm_t         mode,
   output logic [31:0] res,
   output logic        ovf,
   output logic        inexact
);

   logic        inc;
   logic [32:0] rounded;

   always_comb begin
      inc = 1'b0;
      case (mode)
         RM_RNE:  inc = guard && (sticky || mag[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = (guard || sticky) && !sign;
         RM_RDN:  inc = (guard || sticky) && sign;
         default: inc = 1'b0;
      endcase

      // One extra bit so a carry out of the increment is not lost.
      rounded = {1'b0, mag} + {32'd0, inc};
      ovf     = sign ? (rounded > 33'h0_8000_0000) : (rounded > 33'h0_7FFF_FFFF);
      inexact = guard || sticky;

      if (ovf)
         res = sign ? INT32_MIN : INT32_MAX;
      else if (sign)
         res = ~rounded[31:0] + 32'd1;
      else
         res = rounded[31:0];
   end

endmodule

// File: rtl/fp_to_int.sv
// IEEE 754 single to int32 converter, one operation in flight, valid/ready on both sides.
// FP2INT_BARREL_EN: replace the 1-bit/cycle shifter with a barrel shifter at capture.
module fp_to_int
   import fpu_pkg::*;
#(
   parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF,
   parameter int          MAX_RSHIFT = 26
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] opa_in,
   input  logic [1:0]  mode_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        nan_in,
   output logic        overflow,
   output logic        in_exact,
   output logic        zero
);

   localparam int          CNT_W     = (MAX_RSHIFT > 15) ? $clog2(MAX_RSHIFT + 1) : 4;
   localparam logic [31:0] MIN_INT_F = 32'hCF00_0000;

   fp2int_state_t state, state_nxt;

   logic        sign;
   rm_t         mode;
   fp_class_t   cls;
   logic [31:0] mag;
   logic        guard;
   logic        sticky;

   logic [7:0]       exp_f;
   logic [22:0]      frac_f;
   logic [23:0]      sig_f;
   fp_class_t        cls_f;
   logic             left_f;
   logic [CNT_W-1:0] cnt_f;
   logic             accept;

   logic [31:0] rnd_res;
   logic        rnd_ovf;
   logic        rnd_inexact;

   assign exp_f     = opa_in[30:23];
   assign frac_f    = opa_in[22:0];
   assign sig_f     = {exp_f != 8'd0, frac_f};
   assign in_ready  = (state == ST_IDLE) && !rst;
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;

   // Operand classification and shift distance, decided at capture.
   always_comb begin
      cls_f  = CLS_NORM;
      left_f = 1'b0;
      cnt_f  = '0;
      if (exp_f == 8'(EXP_INF))
         cls_f = (frac_f != 23'd0) ? CLS_NAN : CLS_INF;
      else if (exp_f >= 8'(OVF_EXP) && opa_in != MIN_INT_F)
         cls_f = CLS_OVF;
      else if (exp_f >= 8'(INT_EXP)) begin
         left_f = 1'b1;
         cnt_f  = CNT_W'(exp_f - 8'(INT_EXP));
      end else if (8'(INT_EXP) - exp_f > 8'(MAX_RSHIFT))
         cnt_f = CNT_W'(MAX_RSHIFT);
      else
         cnt_f = CNT_W'(8'(INT_EXP) - exp_f);
   end

`ifdef FP2INT_BARREL_EN
   logic [63:0] rsh_f;
   logic [31:0] mag_f;
   logic        guard_f;
   logic        sticky_f;

   // Significand sits above a 32-bit fraction field so guard/sticky fall out of the shift.
   always_comb begin
      rsh_f    = {8'd0, sig_f, 32'd0} >> cnt_f;
      mag_f    = {8'd0, sig_f};
      guard_f  = 1'b0;
      sticky_f = 1'b0;
      if (cls_f == CLS_NORM) begin
         if (left_f)
            mag_f = {8'd0, sig_f} << cnt_f;
         else begin
            mag_f    = rsh_f[63:32];
            guard_f  = rsh_f[31];
            sticky_f = |rsh_f[30:0];
         end
      end
   end
`else
   logic [CNT_W-1:0] cnt;
   logic             left;
`endif

   always_ff @(posedge clk_in) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
`ifdef FP2INT_BARREL_EN
               state_nxt = ST_ROUND;
`else
               state_nxt = (cnt_f != '0) ? ST_SHIFT : ST_ROUND;
`endif
            end
         end
         ST_SHIFT: begin
`ifdef FP2INT_BARREL_EN
            state_nxt = ST_IDLE;
`else
            if (cnt == CNT_W'(1))
               state_nxt = ST_ROUND;
`endif
         end
         ST_ROUND: state_nxt = ST_DONE;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   fp2int_round u_round (
      .mag     (mag),
      .guard   (guard),
      .sticky  (sticky),
      .sign    (sign),
      .mode    (mode),
      .res     (rnd_res),
      .ovf     (rnd_ovf),
      .inexact (rnd_inexact)
   );

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sign     <= 1'b0;
         mode     <= RM_RNE;
         cls      <= CLS_NORM;
         mag      <= '0;
         guard    <= 1'b0;
         sticky   <= 1'b0;
         out      <= '0;
         nan_in   <= 1'b0;
         overflow <= 1'b0;
         in_exact <= 1'b0;
         zero     <= 1'b0;
`ifndef FP2INT_BARREL_EN
         cnt      <= '0;
         left     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            sign <= opa_in[31];
            mode <= rm_t'(mode_in);
            cls  <= cls_f;
`ifdef FP2INT_BARREL_EN
            mag    <= mag_f;
            guard  <= guard_f;
            sticky <= sticky_f;
`else
            mag    <= {8'd0, sig_f};
            guard  <= 1'b0;
            sticky <= 1'b0;
            cnt    <= cnt_f;
            left   <= left_f;
`endif
         end

`ifndef FP2INT_BARREL_EN
         if (state == ST_SHIFT) begin
            cnt <= cnt - CNT_W'(1);
            if (left)
               mag <= mag << 1;
            else begin
               sticky <= sticky | guard;
               guard  <= mag[0];
               mag    <= mag >> 1;
            end
         end
`endif

         if (state == ST_ROUND) begin
            nan_in   <= 1'b0;
            overflow <= 1'b0;
            in_exact <= 1'b0;
            zero     <= 1'b0;
            case (cls)
               CLS_NAN: begin
                  out    <= NAN_RESULT;
                  nan_in <= 1'b1;
               end
               CLS_INF, CLS_OVF: begin
                  out      <= sign ? INT32_MIN : INT32_MAX;
                  overflow <= 1'b1;
               end
               default: begin
                  out      <= rnd_res;
                  overflow <= rnd_ovf;
                  in_exact <= rnd_inexact && !rnd_ovf;
                  zero     <= (rnd_res == 32'd0);
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fp_to_int.sv
// Randomized self-checking bench for fp_to_int against an exact-arithmetic model.
// Honours FP2INT_BARREL_EN for the expected latency.
module tb_fp_to_int;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] opa_in = '0;
   logic [1:0]  mode_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out;
   logic        nan_in, overflow, in_exact, zero;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] val;
      logic [3:0]  flg;   // {nan_in, overflow, in_exact, zero}
      int          lat;   // edges from accept (inclusive) to out_valid
   } exp_t;

   fp_to_int dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opa_in    (opa_in),
      .mode_in   (mode_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .nan_in    (nan_in),
      .overflow  (overflow),
      .in_exact  (in_exact),
      .zero      (zero)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Value = sig * 2^(e-150); round the exact quotient, then range-check.
   function automatic exp_t model(input logic [31:0] f, input logic [1:0] rm);
      exp_t   r;
      bit     s, big, nz, above, tie, inc;
      int     e, sh, cnt;
      longint sig, q, rem, half, v, hi, lo;
      s = f[31];
      e = int'(f[30:23]);
      sig = longint'({e != 0, f[22:0]});
      big = 0; nz = 0; above = 0; tie = 0; inc = 0; q = 0;
      hi = (longint'(1) << 31) - 1;
      lo = -(longint'(1) << 31);
      if (e == 255 || (e >= 158 && f != 32'hCF000000)) cnt = 0;
      else if (e < 150) cnt = (150 - e > 26) ? 26 : 150 - e;
      else cnt = e - 150;
      r.val = '0;
      r.flg = '0;
`ifdef FP2INT_BARREL_EN
      r.lat = 2;
`else
      r.lat = cnt + 2;
`endif
      if (e == 255) begin
         if (f[22:0] != 0) begin r.val = 32'h7FFFFFFF; r.flg = 4'b1000; end
         else begin r.val = s ? 32'h80000000 : 32'h7FFFFFFF; r.flg = 4'b0100; end
         return r;
      end
      if (e >= 150) begin
         if (e - 150 > 30) big = 1;
         else q = sig << (e - 150);
      end else begin
         sh = 150 - e;
         if (sh >= 40) nz = (sig != 0);
         else begin
            q = sig >> sh;
            rem = sig - (q << sh);
            half = longint'(1) << (sh - 1);
            above = rem > half;
            tie = rem == half;
            nz = rem != 0;
         end
      end
      case (rm)
         2'd0: inc = above || (tie && q[0]);
         2'd1: inc = 0;
         2'd2: inc = nz && !s;
         default: inc = nz && s;
      endcase
      q = q + longint'(inc);
      v = s ? -q : q;
      if (big || v > hi || v < lo) begin
         r.val = s ? 32'h80000000 : 32'h7FFFFFFF;
         r.flg = 4'b0100;
      end else begin
         r.val = v[31:0];
         r.flg = {2'b00, nz, v == 0};
      end
      return r;
   endfunction

   task automatic run_op(input logic [31:0] f, input logic [1:0] rm, input bit hold,
                         output logic [31:0] got, output logic [3:0] gflg);
      exp_t e;
      int   n;
      e = model(f, rm);
      n = 0;
      @(negedge clk_in);
      while (!in_ready && n < 50) begin @(negedge clk_in); n++; end
      chk("idle_wait", 32'(in_ready), 32'd1);
      opa_in = f; mode_in = rm; in_valid = 1'b1; out_ready = !hold;
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      opa_in = $urandom;
      mode_in = 2'($urandom);
      n = 1;
      while (!out_valid && n < 200) begin @(posedge clk_in); #1; n++; end
      chk($sformatf("lat_%08h", f), 32'(n), 32'(e.lat));
      got = out;
      gflg = {nan_in, overflow, in_exact, zero};
      chk($sformatf("out_%08h_m%0d", f, rm), out, e.val);
      chk($sformatf("flg_%08h_m%0d", f, rm), 32'(gflg), 32'(e.flg));
   endtask

   logic [31:0] g, held;
   logic [3:0]  gf, heldf;
   logic [31:0] rf;
   bit          seen;

   initial begin
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_flags", 32'({nan_in, overflow, in_exact, zero}), 32'd0);
      @(negedge clk_in); rst = 1'b0;
      #1 chk("post_rst_ready", 32'(in_ready), 32'd1);

      run_op(32'h40200000, 2'd0, 0, g, gf); chk("tp_2p5_rne", g, 32'd2);
      chk("tp_2p5_inexact", 32'(gf[1]), 32'd1);
      run_op(32'h40200000, 2'd1, 0, g, gf); chk("tp_2p5_rtz", g, 32'd2);
      run_op(32'h40600000, 2'd0, 0, g, gf); chk("tp_3p5_rne", g, 32'd4);
      run_op(32'h40600000, 2'd1, 0, g, gf); chk("tp_3p5_rtz", g, 32'd3);
      run_op(32'hC0200000, 2'd3, 0, g, gf); chk("tp_m2p5_rdn", g, 32'hFFFFFFFD);
      run_op(32'h4F000000, 2'd0, 0, g, gf); chk("tp_2e31", g, 32'h7FFFFFFF);
      chk("tp_2e31_ovf", 32'(gf[2]), 32'd1);
      run_op(32'hCF000000, 2'd0, 0, g, gf); chk("tp_m2e31", g, 32'h80000000);
      chk("tp_m2e31_flags", 32'(gf), 32'd0);
      run_op(32'hFF800000, 2'd0, 0, g, gf); chk("tp_ninf", g, 32'h80000000);
      run_op(32'h7FC00000, 2'd0, 0, g, gf); chk("tp_nan", g, 32'h7FFFFFFF);
      chk("tp_nan_flags", 32'(gf), 32'h8);
      run_op(32'h00000001, 2'd0, 0, g, gf); chk("tp_denorm_rne", g, 32'd0);
      chk("tp_denorm_flags", 32'(gf), 32'h3);
      run_op(32'h00000001, 2'd2, 0, g, gf); chk("tp_denorm_rup", g, 32'd1);
      run_op(32'h80000000, 2'd0, 0, g, gf); chk("tp_negzero", 32'(gf), 32'h1);

      // Backpressure: result and flags must hold while the consumer stalls.
      run_op(32'hC0600000, 2'd0, 1, held, heldf);
      repeat (5) @(posedge clk_in);
      #1;
      chk("bp_out", out, held);
      chk("bp_flags", 32'({nan_in, overflow, in_exact, zero}), 32'(heldf));
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk_in); out_ready = 1'b1;

      // Reset with an operation in flight discards it.
      @(negedge clk_in);
      while (!in_ready) @(negedge clk_in);
      opa_in = 32'h40200000; mode_in = 2'd0; in_valid = 1'b1;
      @(posedge clk_in); #1 in_valid = 1'b0;
      @(negedge clk_in); rst = 1'b1;
      @(posedge clk_in); #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out", out, 32'd0);
      @(negedge clk_in); rst = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clk_in); #1 seen |= out_valid; end
      chk("mid_rst_discard", 32'(seen), 32'd0);
      run_op(32'h3F800000, 2'd0, 0, g, gf); chk("tp_one", g, 32'd1);
      chk("tp_one_exact", 32'(gf[1]), 32'd0);

      for (int i = 0; i < 350; i++) begin
         case ($urandom_range(0, 9))
            0: rf = $urandom;
            1: rf = {1'($urandom), 8'd0, 23'($urandom)};
            2: rf = {1'($urandom), 8'd255, (($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom))};
            3: rf = 32'hCF000000;
            default: rf = {1'($urandom), 8'($urandom_range(110, 160)), 23'($urandom)};
         endcase
         run_op(rf, 2'($urandom), 0, g, gf);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
